// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: DEPTH valid/ready slots with bubble collapsing and synchronous flush.
// Define PIPE_STAGE_BUF_OCC_EN to add the registered occupancy output.
module pipe_stage_buf #(
    parameter int              WIDTH   = 32,
    parameter int              DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_STAGE_BUF_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    // Handshake: a word moves across a port only on a cycle where valid and ready
    // are both high at the rising edge; flush drops both readies/valids for that cycle.

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] move;
    logic             chain;
    logic             push;

    // chain carries "the slot above can take a word this edge" from the output side down
    always_comb begin
        move  = '0;
        chain = out_ready && !flush;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            move[i] = v[i] && chain && !flush;
            chain   = !v[i] || move[i];
        end
        in_ready = chain && !flush;
    end

    assign push      = in_valid && in_ready;
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RST_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            v[0] <= push || (v[0] && !move[0]);
            if (push) begin
                d[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= move[i-1] || (v[i] && !move[i]);
                if (move[i-1]) begin
                    d[i] <= d[i-1];
                end
            end
        end
    end

`ifdef PIPE_STAGE_BUF_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);

    logic          pop;
    logic [OW-1:0] count;

    assign pop = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + OW'(1);
        end else if (pop && !push) begin
            count <= count - OW'(1);
        end
    end

    assign occupancy = count;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance share stimulus and are checked
// against an entry/position reference model plus an expected-data scoreboard.
module tb_pipe_stage_buf;

    localparam logic [31:0] RV0 = 32'hDEADBEEF;
    localparam logic [31:0] RV1 = 32'h0BADF00D;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             out_ready;
    logic [1:0]       ir;
    logic [1:0]       ov;
    logic [1:0][31:0] od;
`ifdef PIPE_STAGE_BUF_OCC_EN
    logic [1:0]       occ0;
    logic [1:0]       occ1;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .RST_VAL(RV0)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready)
`ifdef PIPE_STAGE_BUF_OCC_EN
        , .occupancy(occ0)
`endif
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .RST_VAL(RV1)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready)
`ifdef PIPE_STAGE_BUF_OCC_EN
        , .occupancy(occ1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight entries oldest first, each with its distance from the input side
    logic [31:0] e_data [2][8];
    int          e_pos  [2][8];
    int          n_e    [2];
    logic [31:0] stale  [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    int          dep;
    int          lim;
    logic [31:0] rv;
    logic [31:0] exp_od;
    logic [31:0] sb_exp;
    logic        head_out;
    logic        exp_ov;
    logic        exp_ir;
    logic        pop_m;
    logic        push_m;
    logic        sb_empty;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            dep = (k == 0) ? 2 : 3;
            rv  = (k == 0) ? RV0 : RV1;
            if (rst) begin
                chk("rst_out_valid", k, {31'b0, ov[k]}, 32'd0);
                chk("rst_out_data", k, od[k], rv);
                chk("rst_in_ready", k, {31'b0, ir[k]}, {31'b0, !flush});
`ifdef PIPE_STAGE_BUF_OCC_EN
                chk("rst_occupancy", k, {30'b0, ((k == 0) ? occ0 : occ1)}, 32'd0);
`endif
                n_e[k]   = 0;
                stale[k] = rv;
                if (k == 0) exp_q0.delete();
                else        exp_q1.delete();
            end else begin
                head_out = (n_e[k] > 0) && (e_pos[k][0] == dep - 1);
                exp_ov   = head_out && !flush;
                exp_od   = head_out ? e_data[k][0] : stale[k];
                exp_ir   = !flush && ((n_e[k] < dep) || out_ready);
                chk("in_ready", k, {31'b0, ir[k]}, {31'b0, exp_ir});
                chk("out_valid", k, {31'b0, ov[k]}, {31'b0, exp_ov});
                chk("out_data", k, od[k], exp_od);
`ifdef PIPE_STAGE_BUF_OCC_EN
                chk("occupancy", k, {30'b0, ((k == 0) ? occ0 : occ1)}, n_e[k]);
`endif
                // scoreboard: every word the DUT hands downstream must be the oldest one accepted
                if (ov[k] && out_ready) begin
                    sb_empty = 1'b0;
                    sb_exp   = '0;
                    if (k == 0) begin
                        if (exp_q0.size() > 0) sb_exp = exp_q0.pop_front();
                        else                   sb_empty = 1'b1;
                    end else begin
                        if (exp_q1.size() > 0) sb_exp = exp_q1.pop_front();
                        else                   sb_empty = 1'b1;
                    end
                    if (sb_empty) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow dut%0d: got out_data %h while nothing is expected", k, od[k]);
                    end else begin
                        chk("sb_data", k, od[k], sb_exp);
                    end
                end
                // advance the model to the state after the coming edge
                if (flush) begin
                    n_e[k] = 0;
                    if (k == 0) exp_q0.delete();
                    else        exp_q1.delete();
                end else begin
                    pop_m  = exp_ov && out_ready;
                    push_m = in_valid && exp_ir;
                    if (pop_m) begin
                        for (int j = 0; j < n_e[k] - 1; j++) begin
                            e_data[k][j] = e_data[k][j+1];
                            e_pos[k][j]  = e_pos[k][j+1];
                        end
                        n_e[k]--;
                    end
                    for (int j = 0; j < n_e[k]; j++) begin
                        lim = (j == 0) ? dep - 1 : e_pos[k][j-1] - 1;
                        if (e_pos[k][j] < lim) begin
                            e_pos[k][j]++;
                            if (e_pos[k][j] == dep - 1) stale[k] = e_data[k][j];
                        end
                    end
                    if (push_m) begin
                        e_data[k][n_e[k]] = in_data;
                        e_pos[k][n_e[k]]  = 0;
                        n_e[k]++;
                        if (k == 0) exp_q0.push_back(in_data);
                        else        exp_q1.push_back(in_data);
                    end
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // streaming with the downstream always ready
        drive(1'b1, 32'h1, 1'b1, 1'b0);
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // fill while stalled, then release
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 32'h12, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // full buffer with simultaneous enqueue and dequeue
        drive(1'b1, 32'h1d, 1'b0, 1'b0);
        drive(1'b1, 32'h1e, 1'b0, 1'b0);
        drive(1'b1, 32'h1f, 1'b0, 1'b0);
        drive(1'b1, 32'h20, 1'b1, 1'b0);
        drive(1'b1, 32'h21, 1'b1, 1'b0);
        drive(1'b1, 32'h22, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // flush with both sides offering a handshake
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        drive(1'b1, 32'h31, 1'b0, 1'b0);
        drive(1'b1, 32'h32, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // random traffic with a reset landing between edges part way through
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                drive(1'b1, $urandom, 1'b0, 1'b0);
                #1 rst = 1'b1;
                @(negedge clk);
                #1;
                rst      = 1'b0;
                in_valid = 1'b0;
            end else begin
                drive($urandom_range(0, 3) != 0, $urandom,
                      (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                      $urandom_range(0, 19) == 0);
            end
        end

        repeat (8) drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline register for the pipelined datapath: a chain of DEPTH register slots carrying a WIDTH-bit payload with per-slot valid bits, valid/ready handshaking on both sides, bubble collapsing, and synchronous flush. It replaces plain clocked inter-stage registers between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) wherever stall and kill support is needed.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 2, number of register slots (1..8)
- RST_VAL, 0, value loaded into every data slot on reset

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous kill of all in-flight entries
- in_valid  input  1  upstream offers in_data
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  buffer accepts in_data this cycle
- out_valid  output  1  slot DEPTH-1 holds a valid entry
- out_data  output  WIDTH  payload of slot DEPTH-1
- out_ready  input  1  downstream accepts out_data this cycle
- occupancy  output  $clog2(DEPTH+1)  valid slot count (present only with PIPE_STAGE_BUF_OCC_EN)

## Operation
- Slots s[0]..s[DEPTH-1], each with data d[i] and valid v[i]; s[0] is input side, s[DEPTH-1] drives out_data/out_valid directly (no output mux).
- Downstream transfer: out_valid && out_ready. Upstream transfer: in_valid && in_ready.
- move[DEPTH-1] = v[DEPTH-1] && out_ready (when not flushing).
- free[i] = !v[i] || move[i]; move[i] = v[i] && free[i+1] for i < DEPTH-1.
- in_ready = free[0] && !flush (combinational chain from out_ready; accepted).
- On edge: if move[i], s[i+1] loads d[i], v[i+1]=1; if upstream transfer, s[0] loads in_data; slots that empty clear valid.
- Bubble collapsing: a valid entry advances into any empty downstream slot even while out_ready=0.
- Data registers load only on transfer into the slot; an invalid slot keeps its stale data; out_data is stable while out_valid=0.
- Entry order strictly preserved; no entry duplicated or dropped except by flush.
- flush=1: out_valid forced 0 and in_ready forced 0 in that cycle (no handshake on either side); on the edge all v[i] clear; data registers unchanged.

## Timing
- Reset: all v[i]=0, all d[i]=RST_VAL; out_valid=0, out_data=RST_VAL, occupancy=0; in_ready=1 (if flush=0) immediately after reset asserts.
- Latency, empty buffer: accepted at edge k -> out_valid=1 after edge k+DEPTH-1 (DEPTH=1: visible the cycle after acceptance).
- Throughput: one entry per cycle sustained while out_ready=1.
- Full (all v=1) with out_ready=0: in_ready=0, contents frozen.
- Full with out_ready=1: simultaneous enqueue and dequeue, occupancy unchanged.
- Reset mid-operation: state cleared asynchronously; pending handshakes discarded.
- flush and rst both high: rst dominates.

## Configuration
- PIPE_STAGE_BUF_OCC_EN defined: occupancy port present, registered count of valid slots; +1 on upstream-only transfer, −1 on downstream-only transfer, unchanged on both/neither, 0 on flush or reset; never exceeds DEPTH.
- Undefined: occupancy port and counter absent; all other behaviour identical.

## Test plan
- Reset, DEPTH=2, WIDTH=32, RST_VAL=0xDEADBEEF: out_valid=0, out_data=0xDEADBEEF, in_ready=1, occupancy=0.
- Stream 0x1,0x2,0x3 with out_ready=1, DEPTH=3: 0x1 appears on out_data 2 cycles after acceptance edge, then 0x2, 0x3 on consecutive cycles, in_ready stays 1.
- out_ready=0, push 0x10,0x11 into DEPTH=2: both accepted back-to-back, then in_ready=0, out_data=0x10, occupancy=2; raise out_ready -> 0x10 then 0x11 out, in_ready=1 in the same cycle as first dequeue.
- Full DEPTH=2, out_ready=1, in_valid=1 with 0x20: dequeue and enqueue same cycle, occupancy stays 2, order preserved.
- Load 2 entries, assert flush 1 cycle with in_valid=1 and out_ready=1: no handshake that cycle, next cycle out_valid=0, occupancy=0, out_data unchanged.
- Assert rst asynchronously mid-stream (between edges): out_valid drops to 0 and out_data=RST_VAL before next edge.
